// File: rtl/keypad_multitap_encoder.sv
`default_nettype none
// ============================================================================
// Module      : keypad_multitap_encoder
// Description : Scans a 4x4 keypad and debounces it. Phone-style multi-tap
//               presses are turned into one pending ASCII letter, and
//               one-cycle commit / word-submit / clear events are emitted for
//               the downstream game FSM.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               row[3:0]          - raw keypad rows (async, active-high)
//               col[3:0]          - one-hot column drive
//               letter[7:0]       - pending letter ASCII, 8'h00 when none
//               pending           - a letter is pending
//               commit            - 1-cycle pulse, letter committed
//               commit_letter[7:0]- last committed letter (held)
//               word_submit       - 1-cycle pulse, submit with nothing pending
//               clear             - 1-cycle pulse, pending letter discarded
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_multitap_encoder #(
    parameter int SCAN_DIV    = 1000,
    parameter int DEBOUNCE    = 4,
    parameter int TAP_TIMEOUT = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [7:0] letter,
    output logic       pending,
    output logic       commit,
    output logic [7:0] commit_letter,
    output logic       word_submit,
    output logic       clear
);

    localparam int c_DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_DB_W  = $clog2(DEBOUNCE + 1);
    localparam int c_TMR_W = $clog2(TAP_TIMEOUT + 1);

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(SCAN_DIV - 1);
    localparam logic [c_DB_W-1:0]  c_DB_FULL  = c_DB_W'(DEBOUNCE);
    localparam logic [c_TMR_W-1:0] c_TMR_MAX  = c_TMR_W'(TAP_TIMEOUT);

    // Key code layout: {valid, row[1:0], col[1:0]}
    localparam logic [4:0] c_CODE_NONE  = 5'b0_0000;
    localparam logic [3:0] c_KEY_SUBMIT = 4'b1100;   // R3C0
    localparam logic [3:0] c_KEY_CLEAR  = 4'b1101;   // R3C1

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_PENDING = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Letter helpers. Groups 0..7 are rows 0/1, index = row*4 + col.
    // ------------------------------------------------------------------------
    function automatic logic [7:0] f_letter(input logic [2:0] grp, input logic [1:0] idx);
        logic [7:0] base;
        case (grp)
            3'd0:    base = 8'h41;   // ABC
            3'd1:    base = 8'h44;   // DEF
            3'd2:    base = 8'h47;   // GHI
            3'd3:    base = 8'h4A;   // JKL
            3'd4:    base = 8'h4D;   // MNO
            3'd5:    base = 8'h50;   // PQRS
            3'd6:    base = 8'h54;   // TUV
            default: base = 8'h57;   // WXYZ
        endcase
        return base + {6'd0, idx};
    endfunction

    function automatic logic [1:0] f_last_idx(input logic [2:0] grp);
        return ((grp == 3'd5) || (grp == 3'd7)) ? 2'd3 : 2'd2;
    endfunction

    // ------------------------------------------------------------------------
    // Row synchronizer
    // ------------------------------------------------------------------------
    logic [3:0] r_row_s1;
    logic [3:0] r_row_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_row_s1 <= '0;
            r_row_s2 <= '0;
        end else begin
            r_row_s1 <= row;
            r_row_s2 <= r_row_s1;
        end
    end

    // ------------------------------------------------------------------------
    // Column scan
    // ------------------------------------------------------------------------
    logic [c_DIV_W-1:0] r_div;
    logic [1:0]         r_slot;
    logic [3:0]         r_col;
    logic               w_slot_end;
    logic               w_frame_end;

    assign w_slot_end  = (r_div == c_DIV_LAST);
    assign w_frame_end = w_slot_end && (r_slot == 2'd3);
    assign col         = r_col;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div  <= '0;
            r_slot <= 2'd0;
            r_col  <= 4'b0001;
        end else if (w_slot_end) begin
            r_div  <= '0;
            r_slot <= r_slot + 2'd1;
            r_col  <= {r_col[2:0], r_col[3]};
        end else begin
            r_div  <= r_div + c_DIV_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Per-slot detection and frame accumulation. Hits saturate at 2 since
    // any count above one means "no key" for the frame.
    // ------------------------------------------------------------------------
    logic       w_slot_hit;
    logic [1:0] w_row_idx;
    logic [1:0] r_frm_hits;
    logic [3:0] r_frm_key;
    logic [1:0] w_hits_next;
    logic [3:0] w_key_next;
    logic [4:0] w_frame_code;

    always_comb begin
        w_slot_hit = 1'b1;
        w_row_idx  = 2'd0;
        case (r_row_s2)
            4'b0001: w_row_idx = 2'd0;
            4'b0010: w_row_idx = 2'd1;
            4'b0100: w_row_idx = 2'd2;
            4'b1000: w_row_idx = 2'd3;
            default: w_slot_hit = 1'b0;
        endcase
    end

    always_comb begin
        w_hits_next = r_frm_hits;
        w_key_next  = r_frm_key;
        if (w_slot_hit) begin
            w_key_next = {w_row_idx, r_slot};
            if (r_frm_hits != 2'd2) begin
                w_hits_next = r_frm_hits + 2'd1;
            end
        end
        w_frame_code = (w_hits_next == 2'd1) ? {1'b1, w_key_next} : c_CODE_NONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frm_hits <= 2'd0;
            r_frm_key  <= 4'd0;
        end else if (w_frame_end) begin
            r_frm_hits <= 2'd0;
            r_frm_key  <= 4'd0;
        end else if (w_slot_end) begin
            r_frm_hits <= w_hits_next;
            r_frm_key  <= w_key_next;
        end
    end

    // ------------------------------------------------------------------------
    // Debounce: r_db_cnt counts consecutive frames equal to r_cand.
    // ------------------------------------------------------------------------
    logic [4:0]        r_cand;
    logic [4:0]        r_stable;
    logic [c_DB_W-1:0] r_db_cnt;
    logic [c_DB_W-1:0] w_db_cnt_next;
    logic              w_settle;
    logic              w_press;

    always_comb begin
        if (w_frame_code != r_cand) begin
            w_db_cnt_next = c_DB_W'(1);
        end else if (r_db_cnt == c_DB_FULL) begin
            w_db_cnt_next = r_db_cnt;
        end else begin
            w_db_cnt_next = r_db_cnt + c_DB_W'(1);
        end
    end

    assign w_settle = w_frame_end && (w_db_cnt_next == c_DB_FULL) && (w_frame_code != r_stable);
    // Only a none -> key transition is a press; key -> key is silent.
    assign w_press  = w_settle && (r_stable == c_CODE_NONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cand   <= c_CODE_NONE;
            r_stable <= c_CODE_NONE;
            r_db_cnt <= '0;
        end else if (w_frame_end) begin
            r_cand   <= w_frame_code;
            r_db_cnt <= w_db_cnt_next;
            if (w_settle) begin
                r_stable <= w_frame_code;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Multi-tap FSM with registered outputs
    // ------------------------------------------------------------------------
    logic               w_is_letter;
    logic               w_is_submit;
    logic               w_is_clear;
    logic [2:0]         w_grp;
    logic               w_same_tap;
    logic [1:0]         w_idx_adv;

    state_t             r_state;
    logic [2:0]         r_key;
    logic [1:0]         r_idx;
    logic [c_TMR_W-1:0] r_timer;
    logic [7:0]         r_letter;
    logic               r_pending;
    logic               r_commit;
    logic [7:0]         r_commit_letter;
    logic               r_word_submit;
    logic               r_clear;

    assign w_is_letter = (w_frame_code[3] == 1'b0);
    assign w_is_submit = (w_frame_code[3:0] == c_KEY_SUBMIT);
    assign w_is_clear  = (w_frame_code[3:0] == c_KEY_CLEAR);
    assign w_grp       = w_frame_code[2:0];
    assign w_same_tap  = (r_state == S_PENDING) && (w_grp == r_key) && (r_timer < c_TMR_MAX);
    assign w_idx_adv   = (r_idx == f_last_idx(r_key)) ? 2'd0 : r_idx + 2'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_key           <= 3'd0;
            r_idx           <= 2'd0;
            r_timer         <= '0;
            r_letter        <= 8'h00;
            r_pending       <= 1'b0;
            r_commit        <= 1'b0;
            r_commit_letter <= 8'h00;
            r_word_submit   <= 1'b0;
            r_clear         <= 1'b0;
        end else begin
            r_commit      <= 1'b0;
            r_word_submit <= 1'b0;
            r_clear       <= 1'b0;

            if ((r_state == S_PENDING) && (r_timer != c_TMR_MAX)) begin
                r_timer <= r_timer + c_TMR_W'(1);
            end

            if (w_press) begin
                if (w_is_letter) begin
                    if (w_same_tap) begin
                        r_idx    <= w_idx_adv;
                        r_letter <= f_letter(r_key, w_idx_adv);
                    end else begin
                        // New key or timed out: the old letter is dropped.
                        r_key    <= w_grp;
                        r_idx    <= 2'd0;
                        r_letter <= f_letter(w_grp, 2'd0);
                    end
                    r_timer   <= '0;
                    r_state   <= S_PENDING;
                    r_pending <= 1'b1;
                end else if (w_is_submit) begin
                    if (r_state == S_PENDING) begin
                        r_commit        <= 1'b1;
                        r_commit_letter <= r_letter;
                        r_letter        <= 8'h00;
                        r_pending       <= 1'b0;
                        r_timer         <= '0;
                        r_state         <= S_IDLE;
                    end else begin
                        r_word_submit <= 1'b1;
                    end
                end else if (w_is_clear) begin
                    if (r_state == S_PENDING) begin
                        r_clear   <= 1'b1;
                        r_letter  <= 8'h00;
                        r_pending <= 1'b0;
                        r_timer   <= '0;
                        r_state   <= S_IDLE;
                    end
                end
            end
        end
    end

    assign letter        = r_letter;
    assign pending       = r_pending;
    assign commit        = r_commit;
    assign commit_letter = r_commit_letter;
    assign word_submit   = r_word_submit;
    assign clear         = r_clear;

endmodule
`default_nettype wire

// File: tb/tb_keypad_multitap_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_multitap_encoder
// Description : Self-checking bench for keypad_multitap_encoder. A simulated
//               keypad drives rows from the column strobe; a frame-level
//               reference model predicts letters and event pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_multitap_encoder;

    localparam int SCAN_DIV    = 4;
    localparam int DEBOUNCE    = 2;
    localparam int TAP_TIMEOUT = 400;
    localparam int FRAME       = 4 * SCAN_DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] row;
    logic [3:0] col;
    logic [7:0] letter;
    logic       pending;
    logic       commit;
    logic [7:0] commit_letter;
    logic       word_submit;
    logic       clear;

    logic [15:0] held = 16'h0000;   // bit r*4+c = key RrCc held down

    keypad_multitap_encoder #(
        .SCAN_DIV    (SCAN_DIV),
        .DEBOUNCE    (DEBOUNCE),
        .TAP_TIMEOUT (TAP_TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .row           (row),
        .col           (col),
        .letter        (letter),
        .pending       (pending),
        .commit        (commit),
        .commit_letter (commit_letter),
        .word_submit   (word_submit),
        .clear         (clear)
    );

    always #5 clk = ~clk;

    // Physical keypad: a held key connects its row to its column strobe.
    always_comb begin
        row = 4'b0000;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (held[r*4+c] && col[c]) row[r] = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Reference model (frame granularity)
    // ------------------------------------------------------------------------
    string groups [8] = '{"ABC", "DEF", "GHI", "JKL", "MNO", "PQRS", "TUV", "WXYZ"};

    int       total = 0;
    int       bad   = 0;
    int       hist[$];
    int       m_stable;
    bit       m_pend;
    int       m_grp;
    int       m_idx;
    int       m_frame = 0;
    int       m_last_evt;
    logic [7:0] m_commit_letter;
    bit       e_commit, e_submit, e_clear;

    function automatic logic [7:0] exp_letter();
        return m_pend ? 8'(groups[m_grp].getc(m_idx)) : 8'h00;
    endfunction

    // Key index r*4+c seen in a frame, or -1 when zero or several keys show.
    function automatic int frame_code(input logic [15:0] m);
        int found = 0;
        int key   = -1;
        for (int c = 0; c < 4; c++) begin
            int n  = 0;
            int rr = 0;
            for (int r = 0; r < 4; r++) begin
                if (m[r*4+c]) begin
                    n++;
                    rr = r;
                end
            end
            if (n == 1) begin
                found++;
                key = rr * 4 + c;
            end
        end
        return (found == 1) ? key : -1;
    endfunction

    task automatic model_reset();
        hist.delete();
        m_stable        = -1;
        m_pend          = 0;
        m_grp           = 0;
        m_idx           = 0;
        m_commit_letter = 8'h00;
        e_commit        = 0;
        e_submit        = 0;
        e_clear         = 0;
    endtask

    task automatic key_event(input int k);
        int r = k / 4;
        int c = k % 4;
        int elapsed;
        if (r <= 1) begin
            elapsed = FRAME * (m_frame - m_last_evt);
            // Timer reads elapsed-1 at the moment of the next press.
            if (m_pend && (r * 4 + c == m_grp) && (elapsed - 1 < TAP_TIMEOUT)) begin
                m_idx = (m_idx + 1) % groups[m_grp].len();
            end else begin
                m_grp = r * 4 + c;
                m_idx = 0;
            end
            m_pend     = 1;
            m_last_evt = m_frame;
        end else if (k == 12) begin
            if (m_pend) begin
                e_commit        = 1;
                m_commit_letter = exp_letter();
                m_pend          = 0;
            end else begin
                e_submit = 1;
            end
        end else if (k == 13) begin
            if (m_pend) begin
                e_clear = 1;
                m_pend  = 0;
            end
        end
    endtask

    task automatic model_frame(input logic [15:0] m);
        int code = frame_code(m);
        bit all_same;
        m_frame++;
        hist.push_back(code);
        if (hist.size() > DEBOUNCE) void'(hist.pop_front());
        all_same = (hist.size() == DEBOUNCE);
        foreach (hist[j]) if (hist[j] != code) all_same = 0;
        if (all_same && (code != m_stable)) begin
            if (m_stable == -1) key_event(code);
            m_stable = code;
        end
    endtask

    // ------------------------------------------------------------------------
    // Checking and stimulus helpers
    // ------------------------------------------------------------------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // Called at the negedge of cycle i within a frame.
    task automatic check_cycle(input int i);
        chk("col", {28'd0, col}, 32'(1 << (i / SCAN_DIV)));
        chk("commit", {31'd0, commit}, (i == 0) ? {31'd0, e_commit} : 32'd0);
        chk("word_submit", {31'd0, word_submit}, (i == 0) ? {31'd0, e_submit} : 32'd0);
        chk("clear", {31'd0, clear}, (i == 0) ? {31'd0, e_clear} : 32'd0);
        chk("letter", {24'd0, letter}, {24'd0, exp_letter()});
        chk("pending", {31'd0, pending}, {31'd0, m_pend});
        chk("commit_letter", {24'd0, commit_letter}, {24'd0, m_commit_letter});
        if (i == 0) begin
            e_commit = 0;
            e_submit = 0;
            e_clear  = 0;
        end
    endtask

    task automatic run_frame(input logic [15:0] m);
        held = m;
        for (int i = 0; i < FRAME; i++) begin
            check_cycle(i);
            @(negedge clk);
        end
        model_frame(m);
    endtask

    task automatic partial_frame(input logic [15:0] m, input int n);
        held = m;
        for (int i = 0; i < n; i++) begin
            check_cycle(i);
            @(negedge clk);
        end
    endtask

    task automatic tap(input int k, input int hold_f, input int rel_f);
        for (int i = 0; i < hold_f; i++) run_frame(16'd1 << k);
        for (int i = 0; i < rel_f; i++)  run_frame(16'h0000);
    endtask

    // Leaves the bench at the negedge of frame cycle 0 with rst released.
    task automatic do_reset(input bit chk_first, input int cycles);
        if (chk_first) check_cycle(0);
        rst = 1'b1;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // ------------------------------------------------------------------------
    // Directed steps followed by random traffic
    // ------------------------------------------------------------------------
    initial begin
        logic [7:0] wrap_seq [5];
        int         useful   [10];
        wrap_seq = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h50};
        useful   = '{0, 1, 2, 3, 4, 5, 6, 7, 12, 13};

        model_reset();
        do_reset(1'b0, 3);
        chk("rst_col", {28'd0, col}, 32'h1);
        chk("rst_letter", {24'd0, letter}, 32'h00);
        chk("rst_commit_letter", {24'd0, commit_letter}, 32'h00);

        // Single tap then submit
        tap(0, 2, 2);
        chk("tap_a_letter", {24'd0, letter}, 32'h41);
        chk("tap_a_pending", {31'd0, pending}, 32'd1);
        tap(12, 2, 2);
        chk("commit_a_letter", {24'd0, commit_letter}, 32'h41);
        chk("commit_a_pending", {31'd0, pending}, 32'd0);

        // Multi-tap wrap on PQRS
        for (int t = 0; t < 5; t++) begin
            tap(5, 2, 2);
            chk("wrap_seq", {24'd0, letter}, {24'd0, wrap_seq[t]});
        end
        tap(13, 2, 2);

        // Timeout restart, then key change
        tap(2, 2, 32);
        tap(2, 2, 2);
        chk("timeout_restart", {24'd0, letter}, 32'h47);
        tap(4, 2, 2);
        chk("key_change", {24'd0, letter}, 32'h4D);
        tap(13, 2, 2);

        // Timer boundary: 400 cycles between presses advances, 416 restarts
        tap(1, 2, 23);
        tap(1, 2, 2);
        chk("timer_edge_advance", {24'd0, letter}, 32'h45);
        tap(13, 2, 2);
        tap(1, 2, 24);
        tap(1, 2, 2);
        chk("timer_edge_restart", {24'd0, letter}, 32'h44);

        // Clear, then submit with nothing pending
        tap(6, 2, 2);
        tap(13, 2, 2);
        chk("clear_letter", {24'd0, letter}, 32'h00);
        tap(12, 2, 2);
        chk("submit_idle_commit_letter", {24'd0, commit_letter}, 32'h41);

        // Filtering: one-frame glitch, same-column pair, cross-column pair
        tap(1, 1, 3);
        chk("glitch_pending", {31'd0, pending}, 32'd0);
        for (int i = 0; i < 3; i++) run_frame(16'h0011);
        tap(0, 0, 2);
        chk("pair_same_col", {31'd0, pending}, 32'd0);
        for (int i = 0; i < 3; i++) run_frame(16'h0003);
        tap(0, 0, 2);
        chk("pair_cross_col", {31'd0, pending}, 32'd0);

        // Key-to-key roll without release: only the first key registers
        tap(0, 2, 0);
        tap(6, 3, 2);
        chk("roll_letter", {24'd0, letter}, 32'h41);
        tap(13, 2, 2);

        // Reset mid-pending
        tap(1, 2, 2);
        tap(1, 2, 2);
        chk("pre_reset_letter", {24'd0, letter}, 32'h45);
        do_reset(1'b1, 1);
        chk("mid_rst_letter", {24'd0, letter}, 32'h00);
        chk("mid_rst_pending", {31'd0, pending}, 32'd0);
        chk("mid_rst_commit", {31'd0, commit}, 32'd0);
        chk("mid_rst_clear", {31'd0, clear}, 32'd0);
        run_frame(16'h0000);

        // Key held across reset is re-detected as a fresh press
        tap(3, 2, 0);
        do_reset(1'b1, 1);
        tap(3, 2, 2);
        chk("held_over_reset", {24'd0, letter}, 32'h4A);

        // Reset partway through a frame
        partial_frame(16'h0020, 7);
        do_reset(1'b0, 1);
        tap(7, 2, 2);

        // Random traffic
        for (int it = 0; it < 140; it++) begin
            int sel;
            int hold_f;
            int rel_f;
            logic [15:0] m;
            sel    = $urandom_range(0, 9);
            hold_f = $urandom_range(1, 3);
            rel_f  = $urandom_range(0, 3);
            if (sel < 7) begin
                m = 16'd1 << useful[$urandom_range(0, 9)];
            end else if (sel == 7) begin
                m = 16'd1 << $urandom_range(0, 15);
            end else if (sel == 8) begin
                m = (16'd1 << $urandom_range(0, 15)) | (16'd1 << $urandom_range(0, 15));
            end else begin
                m      = 16'h0000;
                hold_f = $urandom_range(20, 30);
            end
            for (int i = 0; i < hold_f; i++) run_frame(m);
            for (int i = 0; i < rel_f; i++)  run_frame(16'h0000);
        end
        tap(0, 0, 3);
        check_cycle(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/keypad_multitap_encoder.md
# keypad_multitap_encoder

Front end of each hangman station (host and player instantiate one each). Scans the 4x4 keypad, debounces it, and converts phone-style multi-tap presses into one pending ASCII letter. It emits one-cycle events for letter commit, word submit and clear, which the game FSM downstream consumes.

## Interface
Parameters:
- SCAN_DIV, 1000: clock cycles each column stays driven.
- DEBOUNCE, 4: consecutive identical scan frames needed to accept a press or a release.
- TAP_TIMEOUT, 100000: cycles after a press during which the same key advances the letter.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- row  in  4  raw keypad row lines, active-high, asynchronous.
- col  out  4  one-hot column drive.
- letter  out  8  ASCII of the pending letter; 8'h00 when none.
- pending  out  1  a letter is pending.
- commit  out  1  one-cycle pulse; the letter is committed.
- commit_letter  out  8  committed letter; held until the next commit.
- word_submit  out  1  one-cycle pulse; submit was pressed with no letter pending.
- clear  out  1  one-cycle pulse; the pending letter was discarded.

## Operation
- **Key map (row, col):**
  - R0C0 ABC, R0C1 DEF, R0C2 GHI, R0C3 JKL.
  - R1C0 MNO, R1C1 PQRS, R1C2 TUV, R1C3 WXYZ.
  - R3C0 submit, R3C1 clear.
  - All other keys are ignored. Group size is 3, except 4 for PQRS and WXYZ.
- **Scan:**
  - row passes through a 2-flop synchronizer.
  - col rotates 0001 -> 0010 -> 0100 -> 1000 -> 0001, SCAN_DIV cycles per slot. A frame is 4 slots.
  - Synchronized row is sampled on the last cycle of each slot.
  - A slot with exactly one row bit set yields that key. A slot with zero bits, or two or more bits, yields nothing for that slot.
  - Frame code = the single detected key. Two or more keys detected in one frame = none.
- **Debounce:**
  - The stable key changes only after DEBOUNCE consecutive frames with the same code.
  - A transition from none to key X generates one press event for X.
  - A key-to-key transition without an intervening stable none generates no event.
- **FSM states:** IDLE, PENDING. Registers: key, idx (2 bits), tap timer (saturating at TAP_TIMEOUT, counting in PENDING).
- **Letter press, IDLE:** key := X, idx := 0, timer := 0, go to PENDING.
- **Letter press, PENDING:**
  - Same key with timer < TAP_TIMEOUT: idx := (idx+1) mod group size, timer := 0.
  - Otherwise (different key, or timeout): key := X, idx := 0, timer := 0. The previous letter is discarded; there is no auto-commit.
- **Submit press:**
  - In PENDING: commit pulse, commit_letter := letter, go to IDLE.
  - In IDLE: word_submit pulse.
- **Clear press:**
  - In PENDING: clear pulse, go to IDLE.
  - In IDLE: no effect.
- **Outputs:** letter = group base + idx while pending, else 8'h00. pending = (state == PENDING).

## Timing
- **Reset values:** col = 0001, letter = 8'h00, pending = 0, commit = 0, commit_letter = 8'h00, word_submit = 0, clear = 0.
- **Reset effect:** all counters cleared, FSM in IDLE.
- **Reset mid-operation:** the pending letter is lost and no pulse is emitted. Debounce history is cleared, so a held key is re-detected as a new press after DEBOUNCE frames.
- **Press latency:**
  - The press event fires on the last cycle of the DEBOUNCE-th consistent frame.
  - letter, pending and the pulses update on the next clock edge.
  - Pulses are exactly 1 cycle wide.
- **Sync delay:** the 2-cycle synchronizer delay means a row change landing in the last 2 cycles of a slot is missed in that slot.
- **Timer boundary:**
  - A press with timer == TAP_TIMEOUT-1 advances the letter.
  - A press with timer == TAP_TIMEOUT restarts the letter at the group's first letter.
- **Simultaneous events:** only one key event is possible per frame, so no event collisions exist. The timer keeps counting during scan.

## Test plan
Bench parameters: SCAN_DIV=4, DEBOUNCE=2, TAP_TIMEOUT=400. The bench drives row[r]=1 only while col selects the pressed key's column.

- **Reset and single tap:** reset, then press/release R0C0, then R3C0 -> after the R0C0 press letter=8'h41, pending=1; after R3C0 one commit pulse, commit_letter=8'h41, pending=0.
- **Multi-tap wrap:** tap R1C1 five times, each release-to-press gap < 400 cycles -> letter sequence 8'h50, 8'h51, 8'h52, 8'h53, 8'h50.
- **Timeout and key change:**
  - Tap R0C2, wait 500 cycles, tap R0C2 -> letter stays 8'h47 (restarted, not 8'h48).
  - Then tap R1C0 -> letter=8'h4D.
- **Submit with nothing pending:** from IDLE press R3C0 -> one word_submit pulse; commit stays 0; commit_letter unchanged.
- **Clear and filtering:**
  - Tap R1C2 then R3C1 -> one clear pulse, letter=8'h00.
  - Glitch of 1 frame on R0C1 -> no event.
  - R0C0 and R1C0 held together -> no event.
- **Reset mid-pending:** pending=1 with letter 8'h45, assert rst for 1 cycle -> all outputs at reset values next cycle, no pulses.
